// File: rtl/trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trap_ctrl: machine-mode trap/mret sequencer driving the CSR priority port. |
// | Optional macro VECTORED_MODE_EN: vectored interrupt targets for mtvec=01.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int TIMER_CAUSE = 7,
  parameter int EXT_CAUSE   = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            inst_bound_i,
  input  logic            timer_irq_i,
  input  logic            ext_irq_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            hold_o,
  output logic            flush_o,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            busy_o
);

  localparam logic [11:0] c_mstatus = 12'h300;
  localparam logic [11:0] c_mepc    = 12'h341;
  localparam logic [11:0] c_mcause  = 12'h342;
  localparam logic [XLEN-1:0] c_irq_bit   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_ecall     = XLEN'(11);
  localparam logic [XLEN-1:0] c_ebreak    = XLEN'(3);
  localparam logic [XLEN-1:0] c_ext_irq   = c_irq_bit | XLEN'(EXT_CAUSE);
  localparam logic [XLEN-1:0] c_timer_irq = c_irq_bit | XLEN'(TIMER_CAUSE);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MSTATUS = 3'd3,
    S_JUMP      = 3'd4,
    S_M_MSTATUS = 3'd5,
    S_M_JUMP    = 3'd6
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;

  logic            w_exc;
  logic            w_irq;
  logic            w_take_trap;
  logic            w_idle;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_target;

  assign w_idle      = (r_state == S_IDLE);
  assign w_exc       = ecall_i | ebreak_i;
  assign w_irq       = mstatus_i[3] & inst_bound_i & (ext_irq_i | timer_irq_i);
  // mret outranks interrupts, so an interrupt only wins when no mret is present.
  assign w_take_trap = w_exc | (~mret_i & w_irq);
  assign w_cause     = ecall_i   ? c_ecall   :
                       ebreak_i  ? c_ebreak  :
                       ext_irq_i ? c_ext_irq : c_timer_irq;
  assign w_base      = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef VECTORED_MODE_EN
  assign w_trap_target = (r_cause[XLEN-1] && mtvec_i[1:0] == 2'b01)
                         ? w_base + {r_cause[XLEN-3:0], 2'b00} : w_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^mtvec_i[1:0];
  assign w_trap_target = w_base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cause <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_take_trap) begin
            r_pc    <= ex_pc_i;
            r_cause <= w_cause;
            r_state <= S_W_MEPC;
          end else if (mret_i) begin
            r_state <= S_M_MSTATUS;
          end
        end
        S_W_MEPC:    r_state <= S_W_MCAUSE;
        S_W_MCAUSE:  r_state <= S_W_MSTATUS;
        S_W_MSTATUS: r_state <= S_JUMP;
        S_M_MSTATUS: r_state <= S_M_JUMP;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the state register so mstatus/mtvec/mepc are used live in the write cycle.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    flush_o     = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    busy_o      = ~w_idle;
    hold_o      = ~w_idle | w_take_trap | mret_i;
    unique case (r_state)
      S_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = c_mepc;
        csr_wdata_o = r_pc;
      end
      S_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = c_mcause;
        csr_wdata_o = r_cause;
      end
      S_W_MSTATUS: begin
        csr_we_o       = 1'b1;
        csr_waddr_o    = c_mstatus;
        csr_wdata_o    = mstatus_i;
        csr_wdata_o[7] = mstatus_i[3];
        csr_wdata_o[3] = 1'b0;
      end
      S_JUMP: begin
        jump_o      = 1'b1;
        flush_o     = 1'b1;
        jump_addr_o = w_trap_target;
      end
      S_M_MSTATUS: begin
        csr_we_o       = 1'b1;
        csr_waddr_o    = c_mstatus;
        csr_wdata_o    = mstatus_i;
        csr_wdata_o[3] = mstatus_i[7];
        csr_wdata_o[7] = 1'b1;
      end
      S_M_JUMP: begin
        jump_o      = 1'b1;
        flush_o     = 1'b1;
        jump_addr_o = mepc_i;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
